// File: rtl/bulls_cows_engine.sv
// Two-player Bulls & Cows controller: captures a secret from each player,
// alternates guesses, scores each guess against the opponent's secret and
// declares a winner or a draw.
module bulls_cows_engine #(
   parameter int unsigned DIGITS    = 4,
   parameter int unsigned DIGIT_W   = 4,
   parameter int unsigned MAX_DIGIT = 9,
   parameter int unsigned MAX_TRIES = 10,
   localparam int unsigned CW = $clog2(DIGITS + 1),
   localparam int unsigned TW = $clog2(MAX_TRIES + 1),
   localparam int unsigned WW = DIGITS * DIGIT_W
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          confirm,
   input  logic [WW-1:0] SW,
   output logic [2:0]    state,
   output logic          player,
   output logic [CW-1:0] bulls,
   output logic [CW-1:0] cows,
   output logic          score_valid,
   output logic          err,
   output logic [1:0]    winner,
   output logic [TW-1:0] tries_p1,
   output logic [TW-1:0] tries_p2
);

   typedef enum logic [2:0] {
      StReadS1 = 3'd0,
      StReadS2 = 3'd1,
      StGuess  = 3'd2,
      StScore  = 3'd3,
      StWin    = 3'd4,
      StDraw   = 3'd5
   } state_e;

   state_e        state_q, state_d;
   logic          player_q, player_d;
   logic [CW-1:0] bulls_q, bulls_d, cows_q, cows_d;
   logic          score_valid_q, score_valid_d, err_q, err_d;
   logic [1:0]    winner_q, winner_d;
   logic [TW-1:0] tries_p1_q, tries_p1_d, tries_p2_q, tries_p2_d;
   logic [WW-1:0] secret1_q, secret1_d, secret2_q, secret2_d, guess_q, guess_d;

   logic          sw_valid;
   logic [WW-1:0] secret_sel;
   logic [CW-1:0] bulls_c, cows_c;
   logic [TW-1:0] tries_cur, tries_inc;

   // Word is legal when every digit is in range and all digits are distinct.
   always_comb begin
      sw_valid = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (SW[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(MAX_DIGIT)) sw_valid = 1'b0;
         for (int j = i + 1; j < DIGITS; j++) begin
            if (SW[i*DIGIT_W +: DIGIT_W] == SW[j*DIGIT_W +: DIGIT_W]) sw_valid = 1'b0;
         end
      end
   end

   // Score the registered guess against the opponent's secret.
   always_comb begin
      secret_sel = player_q ? secret1_q : secret2_q;
      bulls_c    = '0;
      cows_c     = '0;
      for (int i = 0; i < DIGITS; i++) begin
         for (int j = 0; j < DIGITS; j++) begin
            if (guess_q[i*DIGIT_W +: DIGIT_W] == secret_sel[j*DIGIT_W +: DIGIT_W]) begin
               if (i == j) bulls_c = bulls_c + CW'(1);
               else        cows_c  = cows_c + CW'(1);
            end
         end
      end
   end

   // Current player's try count after this score, saturating at the limit.
   always_comb begin
      tries_cur = player_q ? tries_p2_q : tries_p1_q;
      tries_inc = (tries_cur < TW'(MAX_TRIES)) ? tries_cur + TW'(1) : tries_cur;
   end

   // Next-state and output-register logic.
   always_comb begin
      state_d       = state_q;
      player_d      = player_q;
      bulls_d       = bulls_q;
      cows_d        = cows_q;
      score_valid_d = 1'b0;
      err_d         = 1'b0;
      winner_d      = winner_q;
      tries_p1_d    = tries_p1_q;
      tries_p2_d    = tries_p2_q;
      secret1_d     = secret1_q;
      secret2_d     = secret2_q;
      guess_d       = guess_q;
      unique case (state_q)
         StReadS1: begin
            if (confirm) begin
               if (sw_valid) begin
                  secret1_d = SW;
                  state_d   = StReadS2;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StReadS2: begin
            if (confirm) begin
               if (sw_valid) begin
                  secret2_d = SW;
                  player_d  = 1'b0;
                  state_d   = StGuess;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StGuess: begin
            if (confirm) begin
               if (sw_valid) begin
                  guess_d = SW;
                  state_d = StScore;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StScore: begin
            bulls_d       = bulls_c;
            cows_d        = cows_c;
            score_valid_d = 1'b1;
            if (player_q) tries_p2_d = tries_inc;
            else          tries_p1_d = tries_inc;
            if (bulls_c == CW'(DIGITS)) begin
               winner_d = player_q ? 2'd2 : 2'd1;
               state_d  = StWin;
            end else if (player_q && tries_inc == TW'(MAX_TRIES)) begin
               winner_d = 2'd3;
               state_d  = StDraw;
            end else begin
               player_d = ~player_q;
               state_d  = StGuess;
            end
         end
         StWin, StDraw: begin
            if (confirm) begin
               secret1_d  = '0;
               secret2_d  = '0;
               guess_d    = '0;
               bulls_d    = '0;
               cows_d     = '0;
               tries_p1_d = '0;
               tries_p2_d = '0;
               winner_d   = 2'd0;
               player_d   = 1'b0;
               state_d    = StReadS1;
            end
         end
         default: state_d = StReadS1;
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= StReadS1;
         player_q      <= 1'b0;
         bulls_q       <= '0;
         cows_q        <= '0;
         score_valid_q <= 1'b0;
         err_q         <= 1'b0;
         winner_q      <= 2'd0;
         tries_p1_q    <= '0;
         tries_p2_q    <= '0;
         secret1_q     <= '0;
         secret2_q     <= '0;
         guess_q       <= '0;
      end else begin
         state_q       <= state_d;
         player_q      <= player_d;
         bulls_q       <= bulls_d;
         cows_q        <= cows_d;
         score_valid_q <= score_valid_d;
         err_q         <= err_d;
         winner_q      <= winner_d;
         tries_p1_q    <= tries_p1_d;
         tries_p2_q    <= tries_p2_d;
         secret1_q     <= secret1_d;
         secret2_q     <= secret2_d;
         guess_q       <= guess_d;
      end
   end

   assign state       = state_q;
   assign player      = player_q;
   assign bulls       = bulls_q;
   assign cows        = cows_q;
   assign score_valid = score_valid_q;
   assign err         = err_q;
   assign winner      = winner_q;
   assign tries_p1    = tries_p1_q;
   assign tries_p2    = tries_p2_q;

endmodule

// File: tb/tb_bulls_cows_engine.sv
// Self-checking bench for bulls_cows_engine (DIGITS=4, MAX_TRIES=2).
module tb_bulls_cows_engine;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        confirm = 1'b0;
   logic [15:0] SW = '0;
   logic [2:0]  state;
   logic        player;
   logic [2:0]  bulls, cows;
   logic        score_valid, err;
   logic [1:0]  winner;
   logic [1:0]  tries_p1, tries_p2;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [2:0] b;
      logic [2:0] c;
   } exp_t;
   exp_t sb[$];

   bulls_cows_engine #(
      .DIGITS(4), .DIGIT_W(4), .MAX_DIGIT(9), .MAX_TRIES(2)
   ) dut (
      .clock(clock), .reset(reset), .confirm(confirm), .SW(SW),
      .state(state), .player(player), .bulls(bulls), .cows(cows),
      .score_valid(score_valid), .err(err), .winner(winner),
      .tries_p1(tries_p1), .tries_p2(tries_p2)
   );

   always #5 clock = ~clock;

   // Reference scorer: per guess digit, a bull if in place, else a cow if anywhere in secret.
   function automatic exp_t model_score(input logic [15:0] g, input logic [15:0] s);
      exp_t e;
      logic [3:0] gd;
      logic hit;
      e.b = 0;
      e.c = 0;
      for (int i = 0; i < 4; i++) begin
         gd  = g[i*4 +: 4];
         hit = (gd == s[0 +: 4]) || (gd == s[4 +: 4]) || (gd == s[8 +: 4]) || (gd == s[12 +: 4]);
         if (gd == s[i*4 +: 4]) e.b = e.b + 1;
         else if (hit)          e.c = e.c + 1;
      end
      return e;
   endfunction

   task automatic press(input logic [15:0] w);
      @(negedge clock);
      SW      = w;
      confirm = 1'b1;
      @(negedge clock);
      confirm = 1'b0;
   endtask

   task automatic guess(input logic [15:0] w, input logic [15:0] secret);
      sb.push_back(model_score(w, secret));
      press(w);
   endtask

   // Waits (bounded) for score_valid; lat = cycles after the SCORE cycle, -1 on timeout.
   task automatic wait_score(output int lat, output logic [2:0] b, output logic [2:0] c);
      lat = -1;
      b   = 'x;
      c   = 'x;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clock);
         if (score_valid) begin
            lat = k;
            b   = bulls;
            c   = cows;
            break;
         end
      end
   endtask

   task automatic test_reset;
      #1;
      n_checks++;
      if ({state, player, bulls, cows, score_valid, err, winner, tries_p1, tries_p2} !== '0) begin
         n_fail++;
         $display("FAIL reset_values: got st=%0d pl=%0d b=%0d c=%0d sv=%0d err=%0d w=%0d t=%0d/%0d",
                  state, player, bulls, cows, score_valid, err, winner, tries_p1, tries_p2);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_secret_entry;
      press(16'h1123);
      n_checks++;
      if ({err, state} !== {1'b1, 3'd0}) begin
         n_fail++; $display("FAIL dup_digit_err: got err=%0d st=%0d want err=1 st=0", err, state);
      end
      @(negedge clock);
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++; $display("FAIL err_one_cycle: got err=%0d want 0", err);
      end
      press(16'h12A4);
      n_checks++;
      if ({err, state} !== {1'b1, 3'd0}) begin
         n_fail++; $display("FAIL range_err: got err=%0d st=%0d want err=1 st=0", err, state);
      end
      press(16'h1234);
      n_checks++;
      if ({err, state} !== {1'b0, 3'd1}) begin
         n_fail++; $display("FAIL secret1: got err=%0d st=%0d want err=0 st=1", err, state);
      end
      press(16'h5678);
      n_checks++;
      if ({state, player} !== {3'd2, 1'b0}) begin
         n_fail++; $display("FAIL secret2: got st=%0d pl=%0d want st=2 pl=0", state, player);
      end
   endtask

   task automatic test_scoring;
      int lat;
      logic [2:0] b, c;
      exp_t e;
      press(16'h5567);
      n_checks++;
      if ({err, state} !== {1'b1, 3'd2}) begin
         n_fail++; $display("FAIL bad_guess: got err=%0d st=%0d want err=1 st=2", err, state);
      end
      guess(16'h5687, 16'h5678);
      n_checks++;
      if (state !== 3'd3) begin
         n_fail++; $display("FAIL score_state: got st=%0d want 3", state);
      end
      wait_score(lat, b, c);
      e = sb.pop_front();
      n_checks++;
      if ({lat == 1, b, c} !== {1'b1, e.b, e.c}) begin
         n_fail++;
         $display("FAIL score_2_2: got lat=%0d b=%0d c=%0d want lat=1 b=%0d c=%0d",
                  lat, b, c, e.b, e.c);
      end
      n_checks++;
      if ({state, player, tries_p1, tries_p2, winner} !== {3'd2, 1'b1, 2'd1, 2'd0, 2'd0}) begin
         n_fail++;
         $display("FAIL after_score1: got st=%0d pl=%0d t=%0d/%0d w=%0d want 2 1 1/0 0",
                  state, player, tries_p1, tries_p2, winner);
      end
      @(negedge clock);
      n_checks++;
      if (score_valid !== 1'b0) begin
         n_fail++; $display("FAIL sv_one_cycle: got sv=%0d want 0", score_valid);
      end
   endtask

   task automatic test_zero_cross;
      int lat;
      logic [2:0] b, c;
      exp_t e;
      guess(16'h9805, 16'h1234);
      wait_score(lat, b, c);
      e = sb.pop_front();
      n_checks++;
      if ({lat == 1, b, c} !== {1'b1, e.b, e.c}) begin
         n_fail++;
         $display("FAIL score_0_0: got lat=%0d b=%0d c=%0d want lat=1 b=%0d c=%0d",
                  lat, b, c, e.b, e.c);
      end
      n_checks++;
      if ({state, player, tries_p1, tries_p2} !== {3'd2, 1'b0, 2'd1, 2'd1}) begin
         n_fail++;
         $display("FAIL after_score2: got st=%0d pl=%0d t=%0d/%0d want 2 0 1/1",
                  state, player, tries_p1, tries_p2);
      end
   endtask

   task automatic test_win;
      int lat;
      logic [2:0] b, c;
      exp_t e;
      guess(16'h5678, 16'h5678);
      wait_score(lat, b, c);
      e = sb.pop_front();
      n_checks++;
      if ({lat == 1, b, c} !== {1'b1, e.b, e.c}) begin
         n_fail++;
         $display("FAIL score_win: got lat=%0d b=%0d c=%0d want lat=1 b=%0d c=%0d",
                  lat, b, c, e.b, e.c);
      end
      n_checks++;
      if ({state, winner, tries_p1, player} !== {3'd4, 2'd1, 2'd2, 1'b0}) begin
         n_fail++;
         $display("FAIL win_state: got st=%0d w=%0d t1=%0d pl=%0d want 4 1 2 0",
                  state, winner, tries_p1, player);
      end
      press(16'h0000);
      n_checks++;
      if ({state, player, bulls, cows, winner, tries_p1, tries_p2} !== '0) begin
         n_fail++;
         $display("FAIL win_clear: got st=%0d pl=%0d b=%0d c=%0d w=%0d t=%0d/%0d want all 0",
                  state, player, bulls, cows, winner, tries_p1, tries_p2);
      end
   endtask

   task automatic test_draw;
      logic [15:0] g[4];
      logic [15:0] s[4];
      int lat;
      logic [2:0] b, c;
      exp_t e;
      g = '{16'h1234, 16'h5678, 16'h8765, 16'h4321};
      s = '{16'h5678, 16'h1234, 16'h5678, 16'h1234};
      press(16'h1234);
      press(16'h5678);
      for (int k = 0; k < 4; k++) begin
         guess(g[k], s[k]);
         wait_score(lat, b, c);
         e = sb.pop_front();
         n_checks++;
         if ({lat == 1, b, c} !== {1'b1, e.b, e.c}) begin
            n_fail++;
            $display("FAIL draw_score%0d: got lat=%0d b=%0d c=%0d want lat=1 b=%0d c=%0d",
                     k, lat, b, c, e.b, e.c);
         end
      end
      n_checks++;
      if ({state, winner, tries_p1, tries_p2} !== {3'd5, 2'd3, 2'd2, 2'd2}) begin
         n_fail++;
         $display("FAIL draw_state: got st=%0d w=%0d t=%0d/%0d want 5 3 2/2",
                  state, winner, tries_p1, tries_p2);
      end
      press(16'h1234);
      n_checks++;
      if ({state, winner, tries_p1, tries_p2} !== '0) begin
         n_fail++;
         $display("FAIL draw_clear: got st=%0d w=%0d t=%0d/%0d want 0", state, winner,
                  tries_p1, tries_p2);
      end
   endtask

   task automatic test_reset_midgame;
      int lat;
      logic [2:0] b, c;
      exp_t e;
      press(16'h1234);
      press(16'h5678);
      for (int k = 0; k < 2; k++) begin
         guess(k == 0 ? 16'h5687 : 16'h9805, k == 0 ? 16'h5678 : 16'h1234);
         wait_score(lat, b, c);
         e = sb.pop_front();
         n_checks++;
         if ({lat == 1, b, c} !== {1'b1, e.b, e.c}) begin
            n_fail++;
            $display("FAIL mid_score%0d: got lat=%0d b=%0d c=%0d want lat=1 b=%0d c=%0d",
                     k, lat, b, c, e.b, e.c);
         end
      end
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({state, player, bulls, cows, score_valid, err, winner, tries_p1, tries_p2} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got st=%0d pl=%0d b=%0d c=%0d w=%0d t=%0d/%0d want all 0",
                  state, player, bulls, cows, winner, tries_p1, tries_p2);
      end
      @(negedge clock);
      reset = 1'b0;
      press(16'h1234);
      n_checks++;
      if (state !== 3'd1) begin
         n_fail++; $display("FAIL post_reset_entry: got st=%0d want 1", state);
      end
   endtask

   initial begin
      test_reset();
      test_secret_entry();
      test_scoring();
      test_zero_cross();
      test_win();
      test_draw();
      test_reset_midgame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bulls_cows_engine.md
# bulls_cows_engine

Parametrised two-player Bulls & Cows game controller for the Nexys A7 top level. It captures a hidden secret from each player, alternates guesses between them, scores each guess as bulls/cows against the opponent's secret and declares a winner or a draw. It generalises the fixed 4-digit, 16-switch game to N digits of configurable width with an attempt limit, input validation and per-player try counters. Switch debouncing and confirm-button edge detection happen upstream; display decoding happens downstream.

## Interface
- DIGITS, 4: number of digits per secret or guess, 2..8.
- DIGIT_W, 4: bits per digit.
- MAX_DIGIT, 9: largest legal digit value, below 2^DIGIT_W.
- MAX_TRIES, 10: scored guesses allowed per player before a draw, at least 1.
- Derived: CW = $clog2(DIGITS+1), TW = $clog2(MAX_TRIES+1).

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- confirm  in  1  single-cycle confirm pulse, already debounced and edge-detected.
- SW  in  DIGITS*DIGIT_W  digit entry; digit k is SW[k*DIGIT_W +: DIGIT_W], digit DIGITS-1 is leftmost.
- state  out  3  encoded FSM state: 0 READ_S1, 1 READ_S2, 2 GUESS, 3 SCORE, 4 WIN, 5 DRAW.
- player  out  1  player whose turn it is: 0 = P1, 1 = P2.
- bulls  out  CW  bulls in the last scored guess.
- cows  out  CW  cows in the last scored guess.
- score_valid  out  1  one-cycle pulse when bulls/cows update.
- err  out  1  one-cycle pulse when a confirm is rejected.
- winner  out  2  0 none, 1 P1, 2 P2, 3 draw.
- tries_p1, tries_p2  out  TW each  scored guesses per player.

## Operation
- Valid word: every digit ≤ MAX_DIGIT and all DIGITS digits pairwise distinct. Validation is combinational on SW; the result is sampled on confirm.
- READ_S1: confirm with a valid SW loads secret1 and goes to READ_S2. Invalid SW pulses err and stays.
- READ_S2: same as READ_S1, loading secret2. Then go to GUESS with player=0.
- GUESS: confirm with a valid SW registers the guess and goes to SCORE. Invalid SW pulses err and stays. P1 guesses against secret2; P2 guesses against secret1.
- SCORE (exactly one cycle): confirm is ignored here.
  - bulls = number of positions i where guess[i]==secret[i].
  - cows = number of pairs (i,j) with i≠j and guess[i]==secret[j]. Digits are distinct, so each guess digit contributes at most one.
  - Register bulls/cows, pulse score_valid, and increment the current player's tries counter.
  - If bulls==DIGITS: set winner=player+1 and go to WIN.
  - Else if player==1 and the incremented tries_p2==MAX_TRIES: set winner=3 and go to DRAW.
  - Otherwise toggle player and return to GUESS.
- WIN / DRAW: all outputs hold. Confirm clears the secrets, bulls, cows, tries, winner and player, then goes to READ_S1.
- Secrets never reach an output port.

## Timing
- Reset values: state=READ_S1, player=0, bulls=0, cows=0, score_valid=0, err=0, winner=0, tries_p1=0, tries_p2=0. Internal secrets and guess register reset to 0.
- Reset asserted mid-game returns to READ_S1 immediately, without waiting for a clock edge; nothing survives.
- All outputs are registered.
- Confirm sampled at edge N in GUESS: state=SCORE after N. At edge N+1, bulls/cows/tries/score_valid/winner/state update together. score_valid is high for the cycle after N+1 only.
- err goes high for the cycle after the rejecting edge, then drops.
- Confirm held high for k cycles counts as k confirms. The upstream block guarantees single-cycle pulses.
- Tries counters never exceed MAX_TRIES and never wrap.

## Test plan
- Reset mid-GUESS, after two scored guesses: assert reset -> all outputs at reset values, state=0 with no clock edge needed. Release reset; SW=0x1234 and confirm -> state=1.
- DIGITS=4. Secret entry: SW=0x1123 and confirm -> err pulse, state stays 0. Then SW=0x12A4 and confirm -> err pulse. Then SW=0x1234 and confirm -> state=1. Then SW=0x5678 and confirm -> state=2, player=0.
- Scoring: with secret2=0x5678, P1 guesses 0x5687 -> two cycles later bulls=2, cows=2, score_valid=1 for one cycle, tries_p1=1, player=1, state=2.
- Zero score and cross-play: with secret1=0x1234, P2 guesses 0x9805 -> bulls=0, cows=0, tries_p2=1, player=0.
- Win: P1 guesses 0x5678 -> bulls=4, winner=1, state=4. Confirm in WIN -> state=0, all counters 0.
- Draw with MAX_TRIES=2: four non-winning guesses, alternating P1 and P2 -> after P2's second score, winner=3, state=5, tries_p1=tries_p2=2.
